// File: rtl/mem_req_sequencer.sv
// Memory-controller request sequencer: turns whole-line fill/writeback requests into
// word-serial controller transactions and returns one response per request.
module mem_req_sequencer #(
    parameter int WORD_SIZE     = 32,
    parameter int CL_SIZE_WIDTH = 512,
    parameter int ADDR_BITCOUNT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_BITCOUNT-1:0] req_addr,
    input  logic [CL_SIZE_WIDTH-1:0] req_line,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [CL_SIZE_WIDTH-1:0] rsp_line,
    input  logic                     mc_ready,
    output logic [1:0]               mc_op,
    output logic [ADDR_BITCOUNT-1:0] mc_addr,
    output logic [WORD_SIZE-1:0]     mc_wdata,
    input  logic [WORD_SIZE-1:0]     mc_rdata,
    input  logic                     mc_rd_valid,
    input  logic                     mc_tx_done,
    output logic                     busy,
    output logic                     protocol_err
);
    localparam int FILL_COUNT = CL_SIZE_WIDTH / WORD_SIZE;
    // One extra bit so a read can count all FILL_COUNT words and detect overflow.
    localparam int IDX_W = $clog2(FILL_COUNT) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FILL_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(FILL_COUNT);
    localparam logic [ADDR_BITCOUNT-1:0] ADDR_MASK = ~(ADDR_BITCOUNT'(CL_SIZE_WIDTH / 8) - 1'b1);

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b11;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_e;

    state_e                               state_q, state_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic                                 first_q, first_d;
    logic [FILL_COUNT-1:0][WORD_SIZE-1:0] line_q, line_d;
    logic [ADDR_BITCOUNT-1:0]             addr_q, addr_d;
    logic [1:0]                           op_q, op_d;
    logic                                 req_ready_q, req_ready_d;
    logic                                 rsp_valid_q, rsp_valid_d;
    logic                                 rsp_write_q, rsp_write_d;
    logic                                 busy_q, busy_d;
    logic                                 err_q, err_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        first_d     = first_q;
        line_d      = line_q;
        addr_d      = addr_q;
        op_d        = op_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        err_d       = err_q;

        case (state_q)
            S_INIT: begin
                if (mc_rd_valid || mc_tx_done) err_d = 1'b1;
                if (mc_ready) begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (mc_rd_valid || mc_tx_done) err_d = 1'b1;
                if (req_valid) begin
                    // Read buffer starts cleared so short fills leave unfilled words at 0.
                    line_d      = req_write ? req_line : '0;
                    addr_d      = req_addr & ADDR_MASK;
                    idx_d       = '0;
                    first_d     = 1'b1;
                    req_ready_d = 1'b0;
                    state_d     = req_write ? S_WRITE : S_READ;
                    op_d        = req_write ? OP_WRITE : OP_READ;
                end
            end
            S_WRITE: begin
                // First cycle is the controller decode slot: word 0 is held an extra cycle.
                if (first_q)                first_d = 1'b0;
                else if (idx_q != IDX_LAST) idx_d   = idx_q + 1'b1;
                if (mc_tx_done) begin
                    if (idx_q != IDX_LAST) err_d = 1'b1;
                    state_d     = S_RESP;
                    op_d        = OP_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                end
            end
            S_READ: begin
                if (mc_rd_valid) begin
                    if (idx_q == IDX_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        line_d[idx_q[IDX_W-2:0]] = mc_rdata;
                        idx_d                    = idx_q + 1'b1;
                    end
                end
                if (mc_tx_done) begin
                    if (idx_d != IDX_FULL) err_d = 1'b1;
                    state_d     = S_RESP;
                    op_d        = OP_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                end
            end
            S_RESP: begin
                if (mc_rd_valid || mc_tx_done) err_d = 1'b1;
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_write_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            idx_q       <= '0;
            first_q     <= 1'b0;
            line_q      <= '0;
            addr_q      <= '0;
            op_q        <= OP_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            line_q      <= line_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_write    = rsp_write_q;
    assign rsp_line     = (rsp_valid_q && !rsp_write_q) ? line_q : '0;
    assign mc_op        = op_q;
    assign mc_addr      = addr_q;
    assign mc_wdata     = (op_q == OP_WRITE) ? line_q[idx_q[IDX_W-2:0]] : '0;
    assign busy         = busy_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Randomized self-checking bench for mem_req_sequencer: the bench plays the controller and
// predicts each response from the words it handed over.
module tb_mem_req_sequencer;
    localparam int W  = 32;
    localparam int CL = 512;
    localparam int AW = 64;
    localparam int N  = CL / W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [CL-1:0] req_line = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_write;
    logic [CL-1:0] rsp_line;
    logic          mc_ready = 1'b0;
    logic [1:0]    mc_op;
    logic [AW-1:0] mc_addr;
    logic [W-1:0]  mc_wdata, mc_rdata = '0;
    logic          mc_rd_valid = 1'b0, mc_tx_done = 1'b0;
    logic          busy, protocol_err;

    int            n_cmp = 0, n_err = 0;
    logic          exp_err = 1'b0;
    logic [CL-1:0] cur_line;

    always #5 clk = ~clk;

    mem_req_sequencer #(.WORD_SIZE(W), .CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_line(req_line),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_line(rsp_line),
        .mc_ready(mc_ready), .mc_op(mc_op), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_rdata(mc_rdata), .mc_rd_valid(mc_rd_valid), .mc_tx_done(mc_tx_done),
        .busy(busy), .protocol_err(protocol_err)
    );

    task automatic chk(input string tag, input logic [CL-1:0] got, input logic [CL-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CL-1:0] rand_line();
        logic [CL-1:0] l;
        for (int k = 0; k < N; k++) l[k*W +: W] = $urandom;
        return l;
    endfunction

    task automatic check_zero(input string pfx);
        chk({pfx, "_req_ready"}, CL'(req_ready), '0);
        chk({pfx, "_mc_op"}, CL'(mc_op), '0);
        chk({pfx, "_rsp_valid"}, CL'(rsp_valid), '0);
        chk({pfx, "_rsp_write"}, CL'(rsp_write), '0);
        chk({pfx, "_rsp_line"}, rsp_line, '0);
        chk({pfx, "_mc_addr"}, CL'(mc_addr), '0);
        chk({pfx, "_mc_wdata"}, CL'(mc_wdata), '0);
        chk({pfx, "_busy"}, CL'(busy), '0);
        chk({pfx, "_perr"}, CL'(protocol_err), '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        mc_ready = 1'b0; mc_rd_valid = 1'b0; mc_tx_done = 1'b0;
        #1;
        check_zero("rst");
        step();
        step();
        rst_n = 1'b1;
        exp_err = 1'b0;
    endtask

    task automatic bring_up();
        mc_ready = 1'b1;
        step();
        chk("up_req_ready", CL'(req_ready), CL'(1));
    endtask

    // Write line to addr; abort_at >= 0 asserts reset while word abort_at is on the bus.
    task automatic do_write(input logic [AW-1:0] addr, input logic [CL-1:0] line, input int abort_at);
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_line = line;
        step();
        req_valid = 1'b0; req_line = rand_line();
        chk("wr_op", CL'(mc_op), CL'(2'b11));
        chk("wr_addr", CL'(mc_addr), CL'({addr[AW-1:6], 6'd0}));
        chk("wr_busy", CL'(busy), CL'(1));
        chk("wr_req_ready", CL'(req_ready), '0);
        chk("wr_t0_data", CL'(mc_wdata), CL'(line[W-1:0]));
        for (int k = 0; k < N; k++) begin
            step();
            chk("wr_data", CL'(mc_wdata), CL'(line[k*W +: W]));
            chk("wr_op_hold", CL'(mc_op), CL'(2'b11));
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_zero("abort");
                return;
            end
            if (k == N - 1) mc_tx_done = 1'b1;
        end
        step();
        mc_tx_done = 1'b0;
        cur_line = '0;
        chk("wr_rsp_valid", CL'(rsp_valid), CL'(1));
        chk("wr_rsp_write", CL'(rsp_write), CL'(1));
        chk("wr_rsp_line", rsp_line, '0);
        chk("wr_rsp_op", CL'(mc_op), '0);
        chk("wr_perr", CL'(protocol_err), CL'(exp_err));
    endtask

    // Read returning n words (pattern 0xA0+k or random), optional idle gap after word gap_after.
    task automatic do_read(input logic [AW-1:0] addr, input int n, input int gap_after,
                           input int gap_len, input bit pat);
        logic [CL-1:0] exp_line = '0;
        logic [W-1:0]  w;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        step();
        req_valid = 1'b0;
        chk("rd_op", CL'(mc_op), CL'(2'b01));
        chk("rd_addr", CL'(mc_addr), CL'({addr[AW-1:6], 6'd0}));
        chk("rd_busy", CL'(busy), CL'(1));
        for (int k = 0; k < n; k++) begin
            w = pat ? W'(32'hA0 + k) : W'($urandom);
            mc_rd_valid = 1'b1; mc_rdata = w; mc_tx_done = (k == n - 1);
            if (k < N) exp_line[k*W +: W] = w;
            step();
            mc_rd_valid = 1'b0; mc_tx_done = 1'b0; mc_rdata = '0;
            if (k == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    chk("rd_gap_op", CL'(mc_op), CL'(2'b01));
                    step();
                end
            end
        end
        if (n != N) exp_err = 1'b1;
        cur_line = exp_line;
        chk("rd_rsp_valid", CL'(rsp_valid), CL'(1));
        chk("rd_rsp_write", CL'(rsp_write), '0);
        chk("rd_rsp_line", rsp_line, exp_line);
        chk("rd_rsp_op", CL'(mc_op), '0);
        chk("rd_perr", CL'(protocol_err), CL'(exp_err));
    endtask

    task automatic finish_rsp(input int hold);
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_rsp_valid", CL'(rsp_valid), CL'(1));
            chk("hold_rsp_line", rsp_line, cur_line);
            chk("hold_req_ready", CL'(req_ready), '0);
            chk("hold_mc_op", CL'(mc_op), '0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("done_rsp_valid", CL'(rsp_valid), '0);
        chk("done_req_ready", CL'(req_ready), CL'(1));
        chk("done_busy", CL'(busy), '0);
        chk("done_mc_op", CL'(mc_op), '0);
    endtask

    initial begin
        logic [CL-1:0] line;
        logic [AW-1:0] addr;
        int            n;

        do_reset();
        for (int c = 0; c < 10; c++) begin
            step();
            chk("init_req_ready", CL'(req_ready), '0);
            chk("init_mc_op", CL'(mc_op), '0);
        end
        bring_up();

        for (int k = 0; k < N; k++) line[k*W +: W] = W'(32'h1000 + k);
        do_write(64'h1047, line, -1);
        finish_rsp(0);

        do_read(64'h2000, N, 5, 2, 1'b1);
        finish_rsp(0);

        // Request waits behind an unconsumed response, then goes in from IDLE.
        do_read({$urandom, $urandom}, N, -1, 0, 1'b0);
        line = rand_line();
        addr = {$urandom, $urandom};
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_line = line;
        finish_rsp(5);
        do_write(addr, line, -1);
        finish_rsp(0);

        for (int t = 0; t < 8; t++) begin
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) do_write(addr, rand_line(), -1);
            else do_read(addr, N, $urandom_range(0, N - 2), $urandom_range(0, 3), 1'b0);
            finish_rsp($urandom_range(0, 2));
        end

        do_read(64'h3000, 10, 3, 1, 1'b0);
        finish_rsp(0);

        do_write(64'h4000, rand_line(), 7);
        step();
        check_zero("post_abort");
        rst_n = 1'b1;
        exp_err = 1'b0;
        step();
        chk("rearm_req_ready", CL'(req_ready), CL'(1));
        chk("rearm_rsp_valid", CL'(rsp_valid), '0);
        chk("rearm_perr", CL'(protocol_err), '0);

        mc_rd_valid = 1'b1;
        step();
        mc_rd_valid = 1'b0;
        chk("stray_perr", CL'(protocol_err), CL'(1));
        chk("stray_req_ready", CL'(req_ready), CL'(1));
        chk("stray_busy", CL'(busy), '0);

        do_reset();
        bring_up();
        n = N + 2;
        do_read(64'h5000, n, -1, 0, 1'b0);
        finish_rsp(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
